// File: rtl/sample_fifo_writer_pkg.sv
// -----------------------------------------------------------------------------
// sample_fifo_writer_pkg
//   Definitions shared by the sample FIFO write controller and the readout
//   FIFO FSM: FSM state encoding, ADC frame geometry and sample-index width.
// -----------------------------------------------------------------------------
package sample_fifo_writer_pkg;

    // ADC frame geometry: one word per channel, channels 0..NCHAN-1.
    localparam int NCHAN  = 16;
    localparam int CHAN_W = 4;
    localparam int SAMP_W = 7;

    localparam logic [CHAN_W-1:0] FIRST_CHAN = '0;
    localparam logic [CHAN_W-1:0] LAST_CHAN  = CHAN_W'(NCHAN - 1);

    // Write-side capture states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ALIGN = 2'b01,
        ST_WRITE = 2'b10
    } state_t;

endpackage

// File: rtl/sample_fifo_writer_pend.sv
// -----------------------------------------------------------------------------
// pend_counter
//   Saturating up/down counter of complete events awaiting readout.
//   An increment and a decrement in the same cycle cancel; a decrement at
//   zero is ignored; increments stop at 2^PEND_W-1.
//
// Ports:
//   CLK   in   system clock
//   RST   in   synchronous, active-high reset
//   INC   in   one event completed this cycle
//   DEC   in   readout finished one event this cycle
//   PEND  out  complete events awaiting readout (registered)
//   RDY   out  PEND != 0 (registered, tracks PEND)
// -----------------------------------------------------------------------------
module pend_counter #(
    parameter int PEND_W = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              INC,
    input  logic              DEC,
    output logic [PEND_W-1:0] PEND,
    output logic              RDY
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [PEND_W-1:0] pend_next;

    always_comb begin
        // NOTE: default assignment first so every path assigns pend_next and no latch is inferred.
        pend_next = PEND;
        if (INC && !DEC) begin
            if (PEND != PEND_MAX) pend_next = PEND + 1'b1;
        end else if (DEC && !INC) begin
            if (PEND != '0) pend_next = PEND - 1'b1;
        end
    end

    // RDY is derived from the next count so both outputs change on the same edge.
    always_ff @(posedge CLK) begin
        // NOTE: only a handful of flops here, so every register gets an explicit reset value.
        if (RST) begin
            PEND <= '0;
            RDY  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments for all clocked state so readers see pre-edge values.
            PEND <= pend_next;
            RDY  <= (pend_next != '0);
        end
    end

endmodule

// File: rtl/sample_fifo_writer.sv
// -----------------------------------------------------------------------------
// sample_fifo_writer
//   Write-side controller for the per-channel sample readout FIFOs. On an
//   accepted trigger it waits for channel 0 of the ADC frame, then issues one
//   FIFO write per ADC word for SAMP_MAX+1 complete frames. Completed events
//   are counted for the readout FIFO FSM, which returns RD_DONE per event.
//
// Ports:
//   CLK        in   system clock
//   RST        in   synchronous, active-high reset
//   JTAG_MODE  in   JTAG readout owns the FIFOs; blocks and aborts capture
//   TRIG       in   single-cycle trigger pulse
//   SAMP_MAX   in   last sample index of an event
//   ADC_VALID  in   one channel word valid this cycle
//   ADC_CHAN   in   channel index of the current ADC word
//   FIFO_FULL  in   any target FIFO full
//   RD_DONE    in   pulse: readout finished one event
//   WREN       out  FIFO write enable, one cycle after the accepted ADC word
//   WR_SAMP    out  sample index of the write shown on WREN
//   BUSY       out  capture in progress (Align or Write)
//   RDY        out  at least one complete event awaits readout
//   PEND       out  complete events awaiting readout
//   OVFL       out  sticky: a write was lost to FIFO_FULL
// -----------------------------------------------------------------------------
module sample_fifo_writer #(
    parameter int NCHAN  = 16,
    parameter int PEND_W = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              JTAG_MODE,
    input  logic              TRIG,
    input  logic [6:0]        SAMP_MAX,
    input  logic              ADC_VALID,
    input  logic [3:0]        ADC_CHAN,
    input  logic              FIFO_FULL,
    input  logic              RD_DONE,
    output logic              WREN,
    output logic [6:0]        WR_SAMP,
    output logic              BUSY,
    output logic              RDY,
    output logic [PEND_W-1:0] PEND,
    output logic              OVFL
);

    import sample_fifo_writer_pkg::*;

    localparam logic [CHAN_W-1:0] LAST_CH     = CHAN_W'(NCHAN - 1);
    localparam logic [PEND_W-1:0] PEND_MAX    = '1;
    localparam logic [PEND_W-1:0] PEND_ALMOST = PEND_MAX - 1'b1;

    state_t            state;
    logic [SAMP_W-1:0] samp_max_q;   // event length frozen at trigger time
    logic [SAMP_W-1:0] samp_cnt;     // sample index of the frame being received
    logic              done_q;       // event completed, one-cycle pulse
    logic              trig_block;

    // The completion pulse reaches PEND one cycle late; refuse a trigger in
    // that gap too so a full counter can never lose a finished event.
    assign trig_block = (PEND == PEND_MAX) || (done_q && (PEND == PEND_ALMOST));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            samp_max_q <= '0;
            samp_cnt   <= '0;
            WR_SAMP    <= '0;
            WREN       <= 1'b0;
            BUSY       <= 1'b0;
            OVFL       <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            WREN   <= 1'b0;
            done_q <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (TRIG && !JTAG_MODE && !trig_block) begin
                        state      <= ST_ALIGN;
                        BUSY       <= 1'b1;
                        samp_max_q <= SAMP_MAX;
                        samp_cnt   <= '0;
                        WR_SAMP    <= '0;
                    end
                end

                ST_ALIGN: begin
                    if (JTAG_MODE) begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                    end else if (ADC_VALID && (ADC_CHAN == FIRST_CHAN)) begin
                        if (FIFO_FULL) begin
                            state <= ST_IDLE;
                            BUSY  <= 1'b0;
                            OVFL  <= 1'b1;
                        end else begin
                            // Channel 0 of the first frame is the first write.
                            state   <= ST_WRITE;
                            WREN    <= 1'b1;
                            WR_SAMP <= samp_cnt;
                        end
                    end
                end

                ST_WRITE: begin
                    if (JTAG_MODE) begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                    end else if (ADC_VALID) begin
                        if (FIFO_FULL) begin
                            state <= ST_IDLE;
                            BUSY  <= 1'b0;
                            OVFL  <= 1'b1;
                        end else begin
                            // WR_SAMP carries the index of this word, so it
                            // lines up with WREN on the next cycle.
                            WREN    <= 1'b1;
                            WR_SAMP <= samp_cnt;
                            if (ADC_CHAN == LAST_CH) begin
                                if (samp_cnt == samp_max_q) begin
                                    state  <= ST_IDLE;
                                    BUSY   <= 1'b0;
                                    done_q <= 1'b1;
                                end else begin
                                    samp_cnt <= samp_cnt + 1'b1;
                                end
                            end
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

    pend_counter #(
        .PEND_W (PEND_W)
    ) u_pend (
        .CLK  (CLK),
        .RST  (RST),
        .INC  (done_q),
        .DEC  (RD_DONE),
        .PEND (PEND),
        .RDY  (RDY)
    );

endmodule

// File: tb/tb_sample_fifo_writer.sv
// -----------------------------------------------------------------------------
// tb_sample_fifo_writer
//   Directed scenarios for sample_fifo_writer (PEND_W = 2, 16 channels).
//   Inputs change 1 ns after the rising edge; outputs are read at that point
//   or on the falling edge.
// -----------------------------------------------------------------------------
module tb_sample_fifo_writer;

    logic       CLK = 1'b0;
    logic       RST;
    logic       JTAG_MODE;
    logic       TRIG;
    logic [6:0] SAMP_MAX;
    logic       ADC_VALID;
    logic [3:0] ADC_CHAN;
    logic       FIFO_FULL;
    logic       RD_DONE;
    logic       WREN;
    logic [6:0] WR_SAMP;
    logic       BUSY;
    logic       RDY;
    logic [1:0] PEND;
    logic       OVFL;

    int n_pass  = 0;
    int n_total = 0;

    // Write monitor: counts writes and checks WR_SAMP against the index
    // implied by the write's position inside its event (16 writes per sample).
    int wren_cnt  = 0;
    int samp_bad  = 0;
    int ev_idx    = 0;

    sample_fifo_writer #(
        .NCHAN  (16),
        .PEND_W (2)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .JTAG_MODE (JTAG_MODE),
        .TRIG      (TRIG),
        .SAMP_MAX  (SAMP_MAX),
        .ADC_VALID (ADC_VALID),
        .ADC_CHAN  (ADC_CHAN),
        .FIFO_FULL (FIFO_FULL),
        .RD_DONE   (RD_DONE),
        .WREN      (WREN),
        .WR_SAMP   (WR_SAMP),
        .BUSY      (BUSY),
        .RDY       (RDY),
        .PEND      (PEND),
        .OVFL      (OVFL)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (WREN === 1'b1) begin
            if (WR_SAMP !== 7'(ev_idx / 16)) samp_bad++;
            ev_idx++;
            wren_cnt++;
        end else if (BUSY === 1'b0) begin
            ev_idx = 0;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_trig();
        TRIG = 1'b1;
        step();
        TRIG = 1'b0;
    endtask

    task automatic stream(input int start, input int n);
        for (int i = 0; i < n; i++) begin
            ADC_VALID = 1'b1;
            ADC_CHAN  = 4'((start + i) % 16);
            step();
        end
        ADC_VALID = 1'b0;
    endtask

    task automatic run_event(input int smax);
        SAMP_MAX = 7'(smax);
        do_trig();
        stream(0, 16 * (smax + 1));
        step();
    endtask

    task automatic rd_pulse();
        RD_DONE = 1'b1;
        step();
        RD_DONE = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) step();
        n_total++; if (WREN !== 1'b0) $display("FAIL rst_wren: got %b want 0", WREN); else n_pass++;
        n_total++; if (BUSY !== 1'b0) $display("FAIL rst_busy: got %b want 0", BUSY); else n_pass++;
        n_total++; if (RDY !== 1'b0) $display("FAIL rst_rdy: got %b want 0", RDY); else n_pass++;
        n_total++; if (OVFL !== 1'b0) $display("FAIL rst_ovfl: got %b want 0", OVFL); else n_pass++;
        n_total++; if (PEND !== 2'd0) $display("FAIL rst_pend: got %0d want 0", PEND); else n_pass++;
        n_total++; if (WR_SAMP !== 7'd0) $display("FAIL rst_wr_samp: got %0d want 0", WR_SAMP); else n_pass++;
        RST = 1'b0;
        step();
    endtask

    task automatic test_basic_event();
        int w0, b0;
        w0 = wren_cnt; b0 = samp_bad;
        SAMP_MAX = 7'd2;
        do_trig();
        n_total++; if (BUSY !== 1'b1) $display("FAIL basic_busy: got %b want 1", BUSY); else n_pass++;
        stream(5, 11);
        n_total++; if ((wren_cnt - w0) !== 0 || WREN !== 1'b0) $display("FAIL basic_align_nowr: writes=%0d wren=%b want 0/0", wren_cnt - w0, WREN); else n_pass++;
        stream(0, 48);
        n_total++; if (WREN !== 1'b1 || WR_SAMP !== 7'd2) $display("FAIL basic_last_wr: wren=%b samp=%0d want 1/2", WREN, WR_SAMP); else n_pass++;
        n_total++; if (BUSY !== 1'b0 || PEND !== 2'd0) $display("FAIL basic_done_early: busy=%b pend=%0d want 0/0", BUSY, PEND); else n_pass++;
        step();
        n_total++; if ((wren_cnt - w0) !== 48) $display("FAIL basic_count: got %0d want 48", wren_cnt - w0); else n_pass++;
        n_total++; if ((samp_bad - b0) !== 0) $display("FAIL basic_wr_samp_seq: %0d bad indices want 0", samp_bad - b0); else n_pass++;
        n_total++; if (PEND !== 2'd1 || RDY !== 1'b1) $display("FAIL basic_pend: pend=%0d rdy=%b want 1/1", PEND, RDY); else n_pass++;
        n_total++; if (WREN !== 1'b0) $display("FAIL basic_wren_off: got %b want 0", WREN); else n_pass++;
    endtask

    task automatic test_pending();
        run_event(0);
        run_event(0);
        n_total++; if (PEND !== 2'd3) $display("FAIL pend_full: got %0d want 3", PEND); else n_pass++;
        SAMP_MAX = 7'd0;
        do_trig();
        n_total++; if (BUSY !== 1'b0) $display("FAIL pend_trig_refused: busy=%b want 0", BUSY); else n_pass++;
        rd_pulse();
        n_total++; if (PEND !== 2'd2) $display("FAIL pend_dec: got %0d want 2", PEND); else n_pass++;
        do_trig();
        stream(0, 16);
        RD_DONE = 1'b1;
        step();
        RD_DONE = 1'b0;
        n_total++; if (PEND !== 2'd2 || RDY !== 1'b1) $display("FAIL pend_simul: pend=%0d rdy=%b want 2/1", PEND, RDY); else n_pass++;
        rd_pulse();
        rd_pulse();
        n_total++; if (PEND !== 2'd0 || RDY !== 1'b0) $display("FAIL pend_drain: pend=%0d rdy=%b want 0/0", PEND, RDY); else n_pass++;
        rd_pulse();
        n_total++; if (PEND !== 2'd0 || RDY !== 1'b0) $display("FAIL pend_underflow: pend=%0d rdy=%b want 0/0", PEND, RDY); else n_pass++;
    endtask

    task automatic test_overflow();
        int w0;
        w0 = wren_cnt;
        SAMP_MAX = 7'd3;
        do_trig();
        stream(0, 23);
        ADC_VALID = 1'b1; ADC_CHAN = 4'd7; FIFO_FULL = 1'b1;
        step();
        ADC_VALID = 1'b0; FIFO_FULL = 1'b0;
        n_total++; if (WREN !== 1'b0 || BUSY !== 1'b0) $display("FAIL ovfl_abort: wren=%b busy=%b want 0/0", WREN, BUSY); else n_pass++;
        n_total++; if (OVFL !== 1'b1) $display("FAIL ovfl_flag: got %b want 1", OVFL); else n_pass++;
        stream(8, 8);
        step();
        n_total++; if ((wren_cnt - w0) !== 23) $display("FAIL ovfl_count: got %0d want 23", wren_cnt - w0); else n_pass++;
        n_total++; if (PEND !== 2'd0) $display("FAIL ovfl_pend: got %0d want 0", PEND); else n_pass++;
        run_event(0);
        n_total++; if (PEND !== 2'd1 || OVFL !== 1'b1) $display("FAIL ovfl_sticky: pend=%0d ovfl=%b want 1/1", PEND, OVFL); else n_pass++;
        rd_pulse();
    endtask

    task automatic test_jtag_abort();
        int w0;
        w0 = wren_cnt;
        SAMP_MAX = 7'd1;
        do_trig();
        stream(0, 20);
        JTAG_MODE = 1'b1; ADC_VALID = 1'b1; ADC_CHAN = 4'd4;
        step();
        ADC_VALID = 1'b0;
        n_total++; if (WREN !== 1'b0 || BUSY !== 1'b0) $display("FAIL jtag_abort: wren=%b busy=%b want 0/0", WREN, BUSY); else n_pass++;
        stream(5, 11);
        step();
        n_total++; if ((wren_cnt - w0) !== 20) $display("FAIL jtag_count: got %0d want 20", wren_cnt - w0); else n_pass++;
        n_total++; if (PEND !== 2'd0 || OVFL !== 1'b1) $display("FAIL jtag_pend_ovfl: pend=%0d ovfl=%b want 0/1", PEND, OVFL); else n_pass++;
        do_trig();
        step();
        n_total++; if (BUSY !== 1'b0) $display("FAIL jtag_trig_block: busy=%b want 0", BUSY); else n_pass++;
        JTAG_MODE = 1'b0;
        step();
    endtask

    task automatic test_boundary();
        int w0, b0;
        w0 = wren_cnt; b0 = samp_bad;
        run_event(0);
        n_total++; if ((wren_cnt - w0) !== 16) $display("FAIL bnd0_count: got %0d want 16", wren_cnt - w0); else n_pass++;
        n_total++; if ((samp_bad - b0) !== 0 || WR_SAMP !== 7'd0) $display("FAIL bnd0_samp: bad=%0d wr_samp=%0d want 0/0", samp_bad - b0, WR_SAMP); else n_pass++;
        n_total++; if (PEND !== 2'd1) $display("FAIL bnd0_pend: got %0d want 1", PEND); else n_pass++;
        rd_pulse();
        w0 = wren_cnt; b0 = samp_bad;
        SAMP_MAX = 7'd127;
        do_trig();
        stream(0, 100);
        SAMP_MAX = 7'd5;
        stream(100, 1948);
        step();
        n_total++; if ((wren_cnt - w0) !== 2048) $display("FAIL bnd127_count: got %0d want 2048", wren_cnt - w0); else n_pass++;
        n_total++; if ((samp_bad - b0) !== 0 || WR_SAMP !== 7'd127) $display("FAIL bnd127_samp: bad=%0d wr_samp=%0d want 0/127", samp_bad - b0, WR_SAMP); else n_pass++;
        n_total++; if (PEND !== 2'd1 || BUSY !== 1'b0) $display("FAIL bnd127_done: pend=%0d busy=%b want 1/0", PEND, BUSY); else n_pass++;
    endtask

    task automatic test_sync_reset();
        int w0, b0;
        SAMP_MAX = 7'd7;
        do_trig();
        stream(0, 67);
        n_total++; if (WREN !== 1'b1 || WR_SAMP !== 7'd4) $display("FAIL srst_pre: wren=%b wr_samp=%0d want 1/4", WREN, WR_SAMP); else n_pass++;
        RST = 1'b1; ADC_VALID = 1'b1; ADC_CHAN = 4'd3;
        step();
        n_total++; if (WREN !== 1'b0 || BUSY !== 1'b0) $display("FAIL srst_wr: wren=%b busy=%b want 0/0", WREN, BUSY); else n_pass++;
        n_total++; if (PEND !== 2'd0 || RDY !== 1'b0) $display("FAIL srst_pend: pend=%0d rdy=%b want 0/0", PEND, RDY); else n_pass++;
        n_total++; if (OVFL !== 1'b0 || WR_SAMP !== 7'd0) $display("FAIL srst_ovfl: ovfl=%b wr_samp=%0d want 0/0", OVFL, WR_SAMP); else n_pass++;
        RST = 1'b0; ADC_VALID = 1'b0;
        step();
        w0 = wren_cnt; b0 = samp_bad;
        run_event(1);
        n_total++; if ((wren_cnt - w0) !== 32 || (samp_bad - b0) !== 0) $display("FAIL srst_restart: writes=%0d bad=%0d want 32/0", wren_cnt - w0, samp_bad - b0); else n_pass++;
        n_total++; if (PEND !== 2'd1 || WR_SAMP !== 7'd1) $display("FAIL srst_restart_end: pend=%0d wr_samp=%0d want 1/1", PEND, WR_SAMP); else n_pass++;
    endtask

    initial begin
        RST       = 1'b1;
        JTAG_MODE = 1'b0;
        TRIG      = 1'b0;
        SAMP_MAX  = 7'd0;
        ADC_VALID = 1'b0;
        ADC_CHAN  = 4'd0;
        FIFO_FULL = 1'b0;
        RD_DONE   = 1'b0;

        test_reset();
        test_basic_event();
        test_pending();
        test_overflow();
        test_jtag_abort();
        test_boundary();
        test_sync_reset();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sample_fifo_writer.md
Name: sample_fifo_writer

Overview:
- Write-side controller for the per-channel sample readout FIFOs. On an accepted trigger it aligns to the ADC channel frame and writes SAMP_MAX+1 samples × 16 channels into the FIFOs.
- It counts completed events and presents RDY to the readout FIFO FSM. That FSM signals completion of each event back via RD_DONE.
- Sits between ADC deserialiser output and readout FIFO write ports.

Parameters:
- NCHAN, 16, channels per ADC frame; channel index 0..NCHAN-1 on ADC_CHAN.
- PEND_W, 3, width of the pending-event counter; saturates at 2^PEND_W-1.

Ports:
- CLK  input  1  system clock
- RST  input  1  synchronous, active-high reset
- JTAG_MODE  input  1  JTAG readout owns FIFOs; blocks and aborts capture
- TRIG  input  1  single-cycle trigger pulse
- SAMP_MAX  input  7  last sample index (event = SAMP_MAX+1 samples)
- ADC_VALID  input  1  one channel word valid this cycle
- ADC_CHAN  input  4  channel index of current ADC word
- FIFO_FULL  input  1  any target FIFO full
- RD_DONE  input  1  pulse: readout finished one event
- WREN  output  1  FIFO write enable, registered
- WR_SAMP  output  7  sample index of the current write
- BUSY  output  1  capture in progress (Align or Write)
- RDY  output  1  at least one complete event awaits readout
- PEND  output  PEND_W  complete events awaiting readout
- OVFL  output  1  sticky overflow flag

Behaviour:
- Reset values:
  - State = Idle.
  - WREN, BUSY, RDY, OVFL = 0.
  - WR_SAMP and PEND = 0.
  - Latched SAMP_MAX = 0.
- States: Idle, Align, Write.
- Idle:
  - If TRIG && !JTAG_MODE && PEND != max, go to Align.
  - On that transition, latch SAMP_MAX and set WR_SAMP = 0.
  - Otherwise the trigger is dropped.
- Align:
  - Wait for ADC_VALID && ADC_CHAN == 0, then go to Write.
  - That word is written: WREN = 1 on the next cycle.
  - Words with ADC_CHAN != 0 are never written in Align.
- Write:
  - Every ADC_VALID produces WREN = 1 one cycle later. Latency is exactly 1 cycle; the data pipeline matches externally.
  - When ADC_VALID && ADC_CHAN == NCHAN-1:
    - If WR_SAMP == latched SAMP_MAX, return to Idle and increment PEND.
    - Otherwise increment WR_SAMP.
  - WR_SAMP updates together with WREN, so WR_SAMP is valid alongside WREN.
- WR_SAMP does not wrap. The range is 0..latched SAMP_MAX; SAMP_MAX = 127 gives 128 samples.
- BUSY = 1 in Align and Write, registered with the state.
- TRIG during Align or Write is ignored. There is no queueing of triggers.
- FIFO_FULL:
  - Applies when ADC_VALID occurs in Write, or in Align with ADC_CHAN == 0, while FIFO_FULL = 1.
  - Response: suppress WREN, set OVFL, go to Idle, do not increment PEND.
  - OVFL clears only on RST.
- JTAG_MODE in Align or Write: abort to Idle next cycle. No further WREN, no PEND increment, OVFL unaffected.
- PEND rules:
  - Increment on event completion; decrement on RD_DONE.
  - Both in the same cycle: PEND unchanged.
  - RD_DONE with PEND = 0: ignored.
  - PEND saturates; triggers in Idle are refused while PEND is at max.
- RDY = (PEND != 0), registered. It rises the cycle after the completing write cycle.
- RST mid-capture: all outputs return to reset values on the next edge. A partial event is not flagged.

Decomposition:
- Shared package holds:
  - State encoding constants: Idle = 2'b00, Align = 2'b01, Write = 2'b10.
  - NCHAN and last-chip/last-channel constants, shared with the readout FIFO FSM.
- One sub-module is natural: pend_counter, a saturating up/down counter with simultaneous-event handling that drives PEND and RDY.
- The FSM and sample counter stay in the top module.

Test Plan:
- Basic event:
  - SAMP_MAX = 2; TRIG, then continuous ADC_VALID with ADC_CHAN cycling 0..15 starting at 5.
  - Required: no WREN until chan 0; exactly 48 WREN pulses; WR_SAMP steps 0,1,2.
  - PEND = 1 and RDY = 1 on the cycle after the 48th WREN.
- Pending bookkeeping:
  - Capture 3 events with PEND_W = 2 → PEND = 3. A 4th TRIG in Idle is ignored (BUSY stays 0).
  - RD_DONE coincident with a 5th event completion keeps PEND constant.
  - Three RD_DONE pulses → PEND = 0, RDY = 0.
- Overflow:
  - FIFO_FULL = 1 at sample 1, chan 7 (SAMP_MAX = 3).
  - Required: WREN suppressed, state Idle, OVFL = 1, PEND unchanged.
  - OVFL stays 1 through a subsequent good event; clears only after RST.
- JTAG abort:
  - Assert JTAG_MODE mid-Write → no WREN after the next cycle, PEND unchanged.
  - TRIG while JTAG_MODE = 1 → BUSY stays 0.
- Boundary:
  - SAMP_MAX = 0 → 16 writes, WR_SAMP = 0 throughout.
  - SAMP_MAX = 127 → 2048 writes, WR_SAMP reaches 127, no wrap.
  - Changing SAMP_MAX mid-capture has no effect on the current event.
- Sync reset:
  - RST asserted during Write at sample 4 → next edge: WREN = 0, BUSY = 0, PEND = 0, RDY = 0, OVFL = 0.
  - Next TRIG restarts at WR_SAMP = 0.
